// File: rtl/tlc_pkg.sv
// Shared types and default timing constants for the traffic sensor front end.
package tlc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUAL    = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } chan_state_t;

    localparam int unsigned DEB_CYC_DEF   = 4;
    localparam int unsigned HOLD_CYC_DEF  = 3;
    localparam int unsigned STUCK_CYC_DEF = 64;

endpackage

// File: rtl/sensor_chan.sv
// One loop-detector channel: 2-flop synchronizer, debounce/hold FSM and
// stuck-on fault detection. A faulted channel reports traffic (fail-safe).
module sensor_chan
    import tlc_pkg::*;
#(
    parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
    parameter int unsigned STUCK_CYC = STUCK_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_t,
    output logic o_fault
);

    localparam int unsigned AUX_MAX = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
    localparam int unsigned AUX_W   = $clog2(AUX_MAX + 1);
    localparam int unsigned STK_W   = $clog2(STUCK_CYC + 1);

    logic              r_sync1;
    logic              r_sync2;
    chan_state_t       r_state;
    chan_state_t       w_state_nxt;
    logic [AUX_W-1:0]  r_aux;
    logic [AUX_W-1:0]  w_aux_nxt;
    logic [STK_W-1:0]  r_stuck;
    logic [STK_W-1:0]  w_stuck_nxt;
    logic              r_t;
    logic              r_fault;
    logic              w_s;
    logic              w_stuck_hit;

    assign w_s         = r_sync2;
    assign w_stuck_hit = w_s && (r_stuck == STK_W'(STUCK_CYC - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_aux_nxt   = r_aux;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    if (DEB_CYC == 1) begin
                        w_state_nxt = PRESENT;
                    end else begin
                        w_state_nxt = QUAL;
                        w_aux_nxt   = AUX_W'(1);
                    end
                end
            end
            QUAL: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (r_aux == AUX_W'(DEB_CYC - 1)) begin
                    w_state_nxt = PRESENT;
                end else begin
                    w_aux_nxt = r_aux + AUX_W'(1);
                end
            end
            PRESENT: begin
                if (!w_s) begin
                    w_state_nxt = HOLD;
                    w_aux_nxt   = AUX_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (w_s) begin
                    w_state_nxt = PRESENT;
                end else if (r_aux == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_aux_nxt = r_aux - AUX_W'(1);
                end
            end
            FAULT: begin
                // Recovery needs DEB_CYC consecutive lows; any high restarts it.
                if (w_s) begin
                    w_aux_nxt = '0;
                end else if (r_aux == AUX_W'(DEB_CYC - 1)) begin
                    w_state_nxt = IDLE;
                    w_aux_nxt   = '0;
                end else begin
                    w_aux_nxt = r_aux + AUX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_aux_nxt   = '0;
            end
        endcase

        if (w_stuck_hit && (r_state inside {QUAL, PRESENT, HOLD})) begin
            w_state_nxt = FAULT;
            w_aux_nxt   = '0;
        end
    end

    always_comb begin
        w_stuck_nxt = r_stuck;
        if (r_state == FAULT || !w_s) begin
            w_stuck_nxt = '0;
        end else if (r_stuck != STK_W'(STUCK_CYC)) begin
            w_stuck_nxt = r_stuck + STK_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_aux   <= '0;
            r_stuck <= '0;
            r_t     <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_aux   <= w_aux_nxt;
            r_stuck <= w_stuck_nxt;
            r_t     <= (w_state_nxt inside {PRESENT, HOLD, FAULT});
            r_fault <= (w_state_nxt == FAULT);
        end
    end

    assign o_t     = r_t;
    assign o_fault = r_fault;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the two raw vehicle-loop inputs into clean Ta/Tb and fault flags
// for the traffic light controller; the two channels are fully independent.
module traffic_sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
    parameter int unsigned STUCK_CYC = STUCK_CYC_DEF
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic SENSA_RAW,
    input  logic SENSB_RAW,
    output logic Ta,
    output logic Tb,
    output logic FAULTA,
    output logic FAULTB
);

    sensor_chan #(
        .DEB_CYC  (DEB_CYC),
        .HOLD_CYC (HOLD_CYC),
        .STUCK_CYC(STUCK_CYC)
    ) u_chan_a (
        .i_clk  (CLK),
        .i_rst_n(RESET_N),
        .i_raw  (SENSA_RAW),
        .o_t    (Ta),
        .o_fault(FAULTA)
    );

    sensor_chan #(
        .DEB_CYC  (DEB_CYC),
        .HOLD_CYC (HOLD_CYC),
        .STUCK_CYC(STUCK_CYC)
    ) u_chan_b (
        .i_clk  (CLK),
        .i_rst_n(RESET_N),
        .i_raw  (SENSB_RAW),
        .o_t    (Tb),
        .o_fault(FAULTB)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with default timing
// (DEB_CYC=4, HOLD_CYC=3, STUCK_CYC=64).
module tb_traffic_sensor_conditioner;

    logic CLK;
    logic RESET_N;
    logic SENSA_RAW;
    logic SENSB_RAW;
    logic Ta;
    logic Tb;
    logic FAULTA;
    logic FAULTB;

    int unsigned n_vec;
    int unsigned n_err;

    traffic_sensor_conditioner #(
        .DEB_CYC  (4),
        .HOLD_CYC (3),
        .STUCK_CYC(64)
    ) u_dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .SENSA_RAW(SENSA_RAW),
        .SENSB_RAW(SENSB_RAW),
        .Ta       (Ta),
        .Tb       (Tb),
        .FAULTA   (FAULTA),
        .FAULTB   (FAULTB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RESET_N   = 1'b0;
        SENSA_RAW = 1'b0;
        SENSB_RAW = 1'b0;
        step(3);
        chk("rst_ta", Ta, 1'b0);
        chk("rst_tb", Tb, 1'b0);
        chk("rst_fa", FAULTA, 1'b0);
        chk("rst_fb", FAULTB, 1'b0);
        RESET_N = 1'b1;
        step(3);

        // 3-cycle glitch on A must not qualify
        SENSA_RAW = 1'b1;
        step(3);
        SENSA_RAW = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_ta", Ta, 1'b0);
        end
        chk("glitch_tb", Tb, 1'b0);
        chk("glitch_fa", FAULTA, 1'b0);
        chk("glitch_fb", FAULTB, 1'b0);

        // exactly DEB_CYC high samples qualifies; falls HOLD_CYC+2 after raw drop
        SENSA_RAW = 1'b1;
        step(4);
        SENSA_RAW = 1'b0;
        step(1);
        chk("deb4_pre", Ta, 1'b0);
        step(1);
        chk("deb4_rise", Ta, 1'b1);
        step(3);
        chk("deb4_hold", Ta, 1'b1);
        step(1);
        chk("deb4_fall", Ta, 1'b0);
        step(2);

        // 10-cycle vehicle on A
        SENSA_RAW = 1'b1;
        step(5);
        chk("q10_pre", Ta, 1'b0);
        step(1);
        chk("q10_rise", Ta, 1'b1);
        chk("q10_tb", Tb, 1'b0);
        step(4);
        SENSA_RAW = 1'b0;
        step(5);
        chk("q10_hold", Ta, 1'b1);
        step(1);
        chk("q10_fall", Ta, 1'b0);
        chk("q10_tb2", Tb, 1'b0);
        step(2);

        // 2-cycle gap retriggers PRESENT; full hold afterwards proves it
        SENSA_RAW = 1'b1;
        step(8);
        chk("rt_present", Ta, 1'b1);
        SENSA_RAW = 1'b0;
        step(2);
        SENSA_RAW = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("rt_gap", Ta, 1'b1);
        end
        SENSA_RAW = 1'b0;
        step(5);
        chk("rt_hold", Ta, 1'b1);
        step(1);
        chk("rt_fall", Ta, 1'b0);
        step(2);

        // stuck-on B
        SENSB_RAW = 1'b1;
        step(5);
        chk("stk_pre", Tb, 1'b0);
        step(1);
        chk("stk_rise", Tb, 1'b1);
        chk("stk_fb0", FAULTB, 1'b0);
        step(59);
        chk("stk_fb_pre", FAULTB, 1'b0);
        step(1);
        chk("stk_fb_rise", FAULTB, 1'b1);
        chk("stk_tb_flt", Tb, 1'b1);
        step(4);
        SENSB_RAW = 1'b0;
        step(2);
        SENSB_RAW = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("stk_blip_fb", FAULTB, 1'b1);
            chk("stk_blip_tb", Tb, 1'b1);
        end
        SENSB_RAW = 1'b0;
        step(5);
        chk("stk_clr_pre", FAULTB, 1'b1);
        step(1);
        chk("stk_clr_fb", FAULTB, 1'b0);
        chk("stk_clr_tb", Tb, 1'b0);
        chk("stk_ta", Ta, 1'b0);
        chk("stk_fa", FAULTA, 1'b0);
        step(2);

        // both channels together, then A faults while B toggles
        SENSA_RAW = 1'b1;
        SENSB_RAW = 1'b1;
        step(5);
        chk("cc_ta_pre", Ta, 1'b0);
        chk("cc_tb_pre", Tb, 1'b0);
        step(1);
        chk("cc_ta_rise", Ta, 1'b1);
        chk("cc_tb_rise", Tb, 1'b1);
        SENSB_RAW = 1'b0;
        step(5);
        chk("cc_tb_hold", Tb, 1'b1);
        step(1);
        chk("cc_tb_fall", Tb, 1'b0);
        SENSB_RAW = 1'b1;
        step(5);
        chk("cc_tb_pre2", Tb, 1'b0);
        step(1);
        chk("cc_tb_rise2", Tb, 1'b1);
        step(47);
        chk("cc_fa_pre", FAULTA, 1'b0);
        step(1);
        chk("cc_fa_rise", FAULTA, 1'b1);
        chk("cc_ta_flt", Ta, 1'b1);
        chk("cc_fb", FAULTB, 1'b0);
        SENSB_RAW = 1'b0;
        step(5);
        chk("cc_tb_hold3", Tb, 1'b1);
        step(1);
        chk("cc_tb_fall3", Tb, 1'b0);
        chk("cc_fb2", FAULTB, 1'b0);
        chk("cc_fa_keep", FAULTA, 1'b1);
        SENSA_RAW = 1'b0;
        step(5);
        chk("cc_fa_clr_pre", FAULTA, 1'b1);
        step(1);
        chk("cc_fa_clr", FAULTA, 1'b0);
        chk("cc_ta_clr", Ta, 1'b0);
        step(2);

        // asynchronous reset mid-operation, then re-qualify after release
        SENSA_RAW = 1'b1;
        step(6);
        chk("ar_present", Ta, 1'b1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk("ar_ta_async", Ta, 1'b0);
        chk("ar_fa_async", FAULTA, 1'b0);
        step(2);
        chk("ar_ta_held", Ta, 1'b0);
        RESET_N = 1'b1;
        step(5);
        chk("ar_rel_pre", Ta, 1'b0);
        step(1);
        chk("ar_rel_rise", Ta, 1'b1);
        chk("ar_tb", Tb, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream front end for the traffic light controller. It takes two raw vehicle-loop detector inputs and produces the clean Ta and Tb traffic-present signals that the controller consumes.
- Per channel: 2-flop synchronizer, debounce qualification, post-vehicle hold extension, and stuck-on fault detection.
- Fail-safe: a faulted channel reports traffic, so that street is still served.

Parameters:
DEB_CYC, 4, consecutive synchronized samples required to qualify presence, and to clear a fault (range ≥1).
HOLD_CYC, 3, cycles Ta/Tb stay high after the detector drops (range ≥1).
STUCK_CYC, 64, consecutive high samples that declare a stuck-on fault (must be > DEB_CYC).

Ports:
CLK  input  1  single system clock, rising edge.
RESET_N  input  1  asynchronous active-low reset.
SENSA_RAW  input  1  raw street-A loop detector, asynchronous to CLK.
SENSB_RAW  input  1  raw street-B loop detector, asynchronous to CLK.
Ta  output  1  qualified traffic present on A; registered; feeds controller Ta.
Tb  output  1  qualified traffic present on B; registered; feeds controller Tb.
FAULTA  output  1  street-A detector stuck-on; registered.
FAULTB  output  1  street-B detector stuck-on; registered.

Behaviour:
- Interface: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset: while RESET_N=0, all flops clear immediately without waiting for a clock edge. This includes the sync flops, state, and counters. Ta=Tb=FAULTA=FAULTB=0, both channels in IDLE.
- Reset mid-operation behaves identically: outputs drop at once.
- The two channels are fully independent. A and B share no state. Simultaneous events are processed in parallel.
- Per channel, s = 2-flop synchronized raw input. E0 = first edge at which the raw input is sampled at its new level. s shows the new level at edge E0+2.
- Stuck counter (saturating, width clog2(STUCK_CYC+1)):
  - counts consecutive s=1 samples in every state except FAULT;
  - clears on any s=0.
- Aux counter (width clog2(max(DEB_CYC,HOLD_CYC)+1)): shared by QUAL, HOLD and FAULT recovery.
- States:
  - IDLE (T=0): s=1 -> QUAL with aux=1. If DEB_CYC=1, go directly to PRESENT instead.
  - QUAL (T=0): s=0 -> IDLE. s=1 and aux=DEB_CYC-1 -> PRESENT. Otherwise aux+1.
  - PRESENT (T=1): s=0 -> HOLD with aux=HOLD_CYC-1.
  - HOLD (T=1): s=1 -> PRESENT. s=0 and aux=0 -> IDLE. Otherwise aux-1.
  - FAULT (T=1, FAULT=1): s=1 -> aux=0. s=0 -> aux+1. On the DEB_CYC-th consecutive low sample -> IDLE, with T=0 and FAULT=0 on the same edge and no hold.
- Fault entry: from QUAL, PRESENT or HOLD, the edge producing the STUCK_CYC-th consecutive high sample -> FAULT. This takes priority over all other transitions.
- Outputs are registered. They are next-state decoded, so T and FAULT change on the same edge as the state.
- Latencies:
  - T rises after edge E0+DEB_CYC+1.
  - T falls after edge E0+HOLD_CYC+2.
  - FAULT rises after edge E0+STUCK_CYC+1.
  - FAULT clears after edge E0+DEB_CYC+1, where E0 is the falling edge of the raw input.
- Glitch rejection:
  - a high pulse shorter than DEB_CYC samples never asserts T;
  - a low gap shorter than HOLD_CYC samples never deasserts T.

Decomposition:
- Package tlc_pkg holds:
  - channel state enum (IDLE, QUAL, PRESENT, HOLD, FAULT; 3-bit);
  - default constants DEB_CYC_DEF, HOLD_CYC_DEF, STUCK_CYC_DEF.
- One sub-module, sensor_chan: synchronizer, FSM and counters for a single detector. It is instantiated twice (A, B). The top only wires the two instances and forwards the parameters.

Test Plan:
1. Reset: channel A in PRESENT, drop RESET_N between edges -> Ta=0 immediately, before the next edge. Release RESET_N with SENSA_RAW=1 -> Ta stays 0 until edge E0+5, where E0 = first edge after release.
2. Glitch: SENSA_RAW high 3 cycles, DEB_CYC=4 -> Ta never 1. Tb, FAULTA and FAULTB stay 0.
3. Qualify/hold: SENSA_RAW high 10 cycles from E0 -> Ta=1 after E0+5. Raw falls at E1 -> Ta=0 after E1+5 (HOLD_CYC=3). Tb=0 throughout.
4. Hold retrigger: A in PRESENT, raw low 2 cycles then high again -> Ta holds 1 continuously and FSM returns to PRESENT.
5. Stuck fault: SENSB_RAW held high 70 cycles from E0 -> Tb=1 after E0+5, FAULTB=1 after E0+65. Raw low from E1 -> FAULTB=0 and Tb=0 after E1+5. A 2-cycle low blip during FAULT must not clear it.
6. Concurrency: both raws rise on the same cycle -> Ta and Tb assert on the same edge. Then A faults while B toggles normally -> B timing unaffected by A.
